// File: rtl/handshake_coeff_sequencer_pkg.sv
// Shared definitions for the coefficient sequencer: state encoding, default width, soft-clip defaults.
package handshake_coeff_sequencer_pkg;

   typedef logic state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_ISSUE = 1'b1;

   localparam int unsigned COEFF_W = 36;

   // Default soft-clip coefficient set, index order 0..3.
   localparam logic [COEFF_W-1:0] SOFTCLIP_C0 = 36'h0_0000_0053;
   localparam logic [COEFF_W-1:0] SOFTCLIP_C1 = 36'h0_0000_0012;
   localparam logic [COEFF_W-1:0] SOFTCLIP_C2 = 36'h0_0000_00A5;
   localparam logic [COEFF_W-1:0] SOFTCLIP_C3 = 36'h0_0000_007F;

endpackage

// File: rtl/handshake_coeff_sequencer_coeff_regfile.sv
// Coefficient table: NUM_COEFFS x DATA_WIDTH registers, cleared on reset, one write port, one comb read port.
// Addresses at or beyond NUM_COEFFS neither write nor read (read returns 0).
module handshake_coeff_sequencer_coeff_regfile
   import handshake_coeff_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = COEFF_W,
   parameter int unsigned NUM_COEFFS = 4,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_COEFFS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
            if (waddr_i == ADDR_WIDTH'(i)) begin
               mem_q[i] <= wdata_i;
            end
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int unsigned i = 0; i < NUM_COEFFS; i++) begin
         if (raddr_i == ADDR_WIDTH'(i)) begin
            rdata_o = mem_q[i];
         end
      end
   end

endmodule

// File: rtl/handshake_coeff_sequencer.sv
// Emits a NUM_COEFFS-beat coefficient burst per accepted control token; first beat one cycle after acceptance.
// Output is fully registered and held while outs_ready is low; config writes only land while idle.
module handshake_coeff_sequencer
   import handshake_coeff_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = COEFF_W,
   parameter int unsigned NUM_COEFFS = 4,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_we,
   input  logic [ADDR_WIDTH-1:0] cfg_addr,
   input  logic [DATA_WIDTH-1:0] cfg_data,
   output logic                  cfg_busy,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_last
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_COEFFS - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   outs_q, outs_d;
   logic                    last_q, last_d;
   logic [ADDR_WIDTH-1:0]   idx_inc;
   logic [ADDR_WIDTH-1:0]   tbl_raddr;
   logic [DATA_WIDTH-1:0]   tbl_rdata;
   logic                    tbl_we;

   assign idx_inc   = idx_q + ADDR_WIDTH'(1);
   assign tbl_raddr = (state_q == ST_IDLE) ? '0 : idx_inc;
   assign tbl_we    = cfg_we && (state_q == ST_IDLE) && (32'(cfg_addr) < NUM_COEFFS);

   handshake_coeff_sequencer_coeff_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_COEFFS (NUM_COEFFS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_coeff_regfile (
      .clk     (clk),
      .rst     (rst),
      .we_i    (tbl_we),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .raddr_i (tbl_raddr),
      .rdata_o (tbl_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_valid) begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            if (outs_ready && (idx_q == LAST_IDX)) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      ctrl_ready = (state_q == ST_IDLE);
      cfg_busy   = (state_q == ST_ISSUE);
      outs_valid = (state_q == ST_ISSUE);
   end

   // The table read is combinational from registered state, so a write in the
   // token cycle lands after outs has already captured the old table[0].
   always_comb begin
      idx_d  = idx_q;
      outs_d = outs_q;
      last_d = last_q;
      if (state_q == ST_IDLE) begin
         if (ctrl_valid) begin
            idx_d  = '0;
            outs_d = tbl_rdata;
            last_d = (NUM_COEFFS == 1);
         end
      end else if (outs_ready) begin
         if (idx_q != LAST_IDX) begin
            idx_d  = idx_inc;
            outs_d = tbl_rdata;
            last_d = (idx_inc == LAST_IDX);
         end else begin
            last_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         outs_q <= '0;
         last_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         outs_q <= outs_d;
         last_q <= last_d;
      end
   end

   assign outs      = outs_q;
   assign outs_last = last_q;

endmodule
